// File: rtl/gcd_job_arbiter.sv
// gcd_job_arbiter: shares one ee354 subtractive GCD core between two requesters.
// Round-robin arbitration, zero-operand bypass and a watchdog that resets a hung core.
module gcd_job_arbiter #(
  parameter int TO_W    = 10,
  parameter int TIMEOUT = 1023
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Req0,
  input  logic [7:0] A0,
  input  logic [7:0] B0,
  input  logic       Req1,
  input  logic [7:0] A1,
  input  logic [7:0] B1,
  output logic       Gnt0,
  output logic       Gnt1,
  output logic       Done0,
  output logic       Done1,
  output logic [7:0] Result,
  output logic       Err,
  output logic       Busy,
  output logic       Core_Start,
  output logic       Core_Ack,
  output logic [7:0] Core_Ain,
  output logic [7:0] Core_Bin,
  output logic       Core_Reset,
  input  logic       Core_Done,
  input  logic [7:0] Core_GCD
);

  typedef enum logic [4:0] {
    IDLE = 5'b00001,
    LOAD = 5'b00010,
    RUN  = 5'b00100,
    ACK  = 5'b01000,
    BYP  = 5'b10000
  } state_t;

  state_t          state, next_state;
  logic [TO_W-1:0] watchdog, watchdog_next;
  logic            owner, owner_next;
  logic            last_served, last_served_next;
  logic            winner;
  logic [7:0]      win_a, win_b;

  logic            gnt0_next, gnt1_next, done0_next, done1_next, err_next, busy_next;
  logic            start_next, ack_next, core_reset_next;
  logic [7:0]      result_next, ain_next, bin_next;

  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= next_state;
  end

  // Every output is the registered image of the value decided in the current state.
  always_comb begin
    next_state       = state;
    watchdog_next    = watchdog;
    owner_next       = owner;
    last_served_next = last_served;
    winner           = 1'b0;
    win_a            = A0;
    win_b            = B0;
    gnt0_next        = 1'b0;
    gnt1_next        = 1'b0;
    done0_next       = 1'b0;
    done1_next       = 1'b0;
    err_next         = 1'b0;
    start_next       = 1'b0;
    ack_next         = 1'b0;
    core_reset_next  = 1'b0;
    result_next      = Result;
    ain_next         = Core_Ain;
    bin_next         = Core_Bin;

    case (state)
      IDLE: begin
        if (Req0 || Req1) begin
          // On a tie the requester that was not served last wins.
          winner     = (Req0 && Req1) ? ~last_served : Req1;
          win_a      = winner ? A1 : A0;
          win_b      = winner ? B1 : B0;
          ain_next   = win_a;
          bin_next   = win_b;
          owner_next = winner;
          gnt0_next  = ~winner;
          gnt1_next  = winner;
          if (win_a == 8'd0 || win_b == 8'd0) begin
            next_state = BYP;
          end else begin
            next_state = LOAD;
            start_next = 1'b1;
          end
        end
      end
      LOAD: begin
        watchdog_next = '0;
        next_state    = RUN;
      end
      RUN: begin
        watchdog_next = watchdog + TO_W'(1);
        if (Core_Done) begin
          result_next = Core_GCD;
          done0_next  = ~owner;
          done1_next  = owner;
          ack_next    = 1'b1;
          next_state  = ACK;
        end else if (watchdog == TO_W'(TIMEOUT)) begin
          result_next      = 8'd0;
          done0_next       = ~owner;
          done1_next       = owner;
          err_next         = 1'b1;
          core_reset_next  = 1'b1;
          last_served_next = owner;
          next_state       = IDLE;
        end
      end
      ACK: begin
        last_served_next = owner;
        next_state       = IDLE;
      end
      BYP: begin
        // gcd(0,x) = x and gcd(0,0) = 0, so the OR of the operands is the answer.
        result_next      = Core_Ain | Core_Bin;
        done0_next       = ~owner;
        done1_next       = owner;
        last_served_next = owner;
        next_state       = IDLE;
      end
      default: next_state = IDLE;
    endcase

    busy_next = (next_state != IDLE);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      watchdog    <= '0;
      owner       <= 1'b0;
      last_served <= 1'b1;
      Gnt0        <= 1'b0;
      Gnt1        <= 1'b0;
      Done0       <= 1'b0;
      Done1       <= 1'b0;
      Result      <= 8'd0;
      Err         <= 1'b0;
      Busy        <= 1'b0;
      Core_Start  <= 1'b0;
      Core_Ack    <= 1'b0;
      Core_Ain    <= 8'd0;
      Core_Bin    <= 8'd0;
      Core_Reset  <= 1'b0;
    end else begin
      watchdog    <= watchdog_next;
      owner       <= owner_next;
      last_served <= last_served_next;
      Gnt0        <= gnt0_next;
      Gnt1        <= gnt1_next;
      Done0       <= done0_next;
      Done1       <= done1_next;
      Result      <= result_next;
      Err         <= err_next;
      Busy        <= busy_next;
      Core_Start  <= start_next;
      Core_Ack    <= ack_next;
      Core_Ain    <= ain_next;
      Core_Bin    <= bin_next;
      Core_Reset  <= core_reset_next;
    end
  end

endmodule
